move_check_requester: RTL and testbench

//  Initiator side of the piece-checker handshake (valid_input -> valid_output/valid_move).

---
 rtl/move_check_requester.sv | 192 +++++++++++++++++++
 tb/tb_move_check_requester.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/move_check_requester.sv
// Initiator side of the piece-checker handshake.
// Accepts one move request, runs the cheap pre-checks, fires a one-cycle start
// pulse at the checker selected by the source piece kind, waits (bounded) for
// that checker's done and returns a single legal/illegal result with a reason.
// board_in packs board[y][x] at bits [(y*8+x)*4 +: 4]; 4'd15 = empty square,
// otherwise {colour, kind[2:0]}.
module move_check_requester #(
    parameter int unsigned TIMEOUT_CYCLES = 64,
    parameter int unsigned NUM_CHECKERS   = 6
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic                    side,
    input  logic [2:0]              old_x,
    input  logic [2:0]              old_y,
    input  logic [2:0]              new_x,
    input  logic [2:0]              new_y,
    input  logic [255:0]            board_in,
    output logic [2:0]              chk_old_x,
    output logic [2:0]              chk_old_y,
    output logic [2:0]              chk_new_x,
    output logic [2:0]              chk_new_y,
    output logic [2:0]              chk_h_delta,
    output logic [2:0]              chk_v_delta,
    output logic [3:0]              chk_piece_type,
    output logic [NUM_CHECKERS-1:0] chk_valid_input,
    input  logic [NUM_CHECKERS-1:0] chk_done,
    input  logic [NUM_CHECKERS-1:0] chk_move_ok,
    output logic                    result_valid,
    output logic                    result_legal,
    output logic [2:0]              result_code
);

    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    localparam logic [2:0] CODE_OK         = 3'd0;
    localparam logic [2:0] CODE_ILLEGAL    = 3'd1;
    localparam logic [2:0] CODE_EMPTY_SRC  = 3'd2;
    localparam logic [2:0] CODE_WRONG_SIDE = 3'd3;
    localparam logic [2:0] CODE_OWN_DEST   = 3'd4;
    localparam logic [2:0] CODE_NULL_MOVE  = 3'd5;
    localparam logic [2:0] CODE_TIMEOUT    = 3'd6;
    localparam logic [2:0] CODE_BAD_PIECE  = 3'd7;

    localparam logic [3:0] EMPTY = 4'd15;

    typedef enum logic [2:0] {
        S_IDLE,
        S_PRECHECK,
        S_ISSUE,
        S_WAIT,
        S_DONE
    } state_t;

    state_t                  state_q, state_d;
    logic                    side_q;
    logic [CNT_W-1:0]        wait_cnt;
    logic                    load_res;
    logic                    res_legal_d;
    logic [2:0]              res_code_d;
    logic [3:0]              dest_val;
    logic [2:0]              src_kind;
    logic [NUM_CHECKERS-1:0] kind_onehot;
    logic                    done_sel;
    logic                    ok_sel;
    logic                    accept;

    function automatic logic [2:0] abs_diff(input logic [2:0] a, input logic [2:0] b);
        return (a >= b) ? (a - b) : (b - a);
    endfunction

    assign accept      = (state_q == S_IDLE) && req_valid;
    assign src_kind    = chk_piece_type[2:0];
    assign dest_val    = board_in[{chk_new_y, chk_new_x, 2'b00} +: 4];
    assign kind_onehot = NUM_CHECKERS'(1) << src_kind;
    assign done_sel    = |(chk_done & kind_onehot);
    assign ok_sel      = |(chk_move_ok & kind_onehot);

    assign req_ready       = (state_q == S_IDLE);
    assign result_valid    = (state_q == S_DONE);
    assign chk_valid_input = (state_q == S_ISSUE) ? kind_onehot : '0;

    // State register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state and result selection; pre-checks in priority order
    always_comb begin
        state_d     = state_q;
        load_res    = 1'b0;
        res_legal_d = 1'b0;
        res_code_d  = CODE_OK;
        case (state_q)
            S_IDLE: begin
                if (req_valid) state_d = S_PRECHECK;
            end
            S_PRECHECK: begin
                load_res = 1'b1;
                state_d  = S_DONE;
                if ((chk_old_x == chk_new_x) && (chk_old_y == chk_new_y)) begin
                    res_code_d = CODE_NULL_MOVE;
                end else if (chk_piece_type == EMPTY) begin
                    res_code_d = CODE_EMPTY_SRC;
                end else if (32'(src_kind) >= NUM_CHECKERS) begin
                    res_code_d = CODE_BAD_PIECE;
                end else if (chk_piece_type[3] != side_q) begin
                    res_code_d = CODE_WRONG_SIDE;
                end else if ((dest_val != EMPTY) && (dest_val[3] == side_q)) begin
                    res_code_d = CODE_OWN_DEST;
                end else begin
                    load_res = 1'b0;
                    state_d  = S_ISSUE;
                end
            end
            S_ISSUE: begin
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (done_sel) begin
                    load_res    = 1'b1;
                    res_legal_d = ok_sel;
                    res_code_d  = ok_sel ? CODE_OK : CODE_ILLEGAL;
                    state_d     = S_DONE;
                end else if (wait_cnt == CNT_LAST) begin
                    load_res   = 1'b1;
                    res_code_d = CODE_TIMEOUT;
                    state_d    = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Latch request fields, deltas and source square at accept
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            side_q         <= 1'b0;
            chk_old_x      <= '0;
            chk_old_y      <= '0;
            chk_new_x      <= '0;
            chk_new_y      <= '0;
            chk_h_delta    <= '0;
            chk_v_delta    <= '0;
            chk_piece_type <= '0;
        end else if (accept) begin
            side_q         <= side;
            chk_old_x      <= old_x;
            chk_old_y      <= old_y;
            chk_new_x      <= new_x;
            chk_new_y      <= new_y;
            chk_h_delta    <= abs_diff(new_x, old_x);
            chk_v_delta    <= abs_diff(new_y, old_y);
            chk_piece_type <= board_in[{old_y, old_x, 2'b00} +: 4];
        end
    end

    // WAIT-cycle counter, cleared while the start pulse is out
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wait_cnt <= '0;
        end else if (state_q == S_ISSUE) begin
            wait_cnt <= '0;
        end else if ((state_q == S_WAIT) && !done_sel && (wait_cnt != CNT_LAST)) begin
            wait_cnt <= wait_cnt + 1'b1;
        end
    end

    // Result fields, loaded on entry to DONE and held until the next one
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            result_legal <= 1'b0;
            result_code  <= CODE_OK;
        end else if (load_res) begin
            result_legal <= res_legal_d;
            result_code  <= res_code_d;
        end
    end

endmodule

// File: tb/tb_move_check_requester.sv
// Self-checking bench for move_check_requester: directed scenarios followed by
// randomized boards/moves, compared against a rule-level reference model.
module tb_move_check_requester;

    localparam int TO = 64;
    localparam int NC = 6;
    localparam int RUN_CYC = 80;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          req_valid = 1'b0;
    logic          req_ready;
    logic          side = 1'b0;
    logic [2:0]    old_x = '0, old_y = '0, new_x = '0, new_y = '0;
    logic [255:0]  board_in = '0;
    logic [2:0]    chk_old_x, chk_old_y, chk_new_x, chk_new_y;
    logic [2:0]    chk_h_delta, chk_v_delta;
    logic [3:0]    chk_piece_type;
    logic [NC-1:0] chk_valid_input;
    logic [NC-1:0] chk_done = '0;
    logic [NC-1:0] chk_move_ok = '0;
    logic          result_valid, result_legal;
    logic [2:0]    result_code;

    logic [3:0] brd [8][8];
    int n_cmp = 0;
    int n_err = 0;

    move_check_requester #(.TIMEOUT_CYCLES(TO), .NUM_CHECKERS(NC)) dut (
        .clk(clk), .reset_n(reset_n), .req_valid(req_valid), .req_ready(req_ready),
        .side(side), .old_x(old_x), .old_y(old_y), .new_x(new_x), .new_y(new_y),
        .board_in(board_in), .chk_old_x(chk_old_x), .chk_old_y(chk_old_y),
        .chk_new_x(chk_new_x), .chk_new_y(chk_new_y), .chk_h_delta(chk_h_delta),
        .chk_v_delta(chk_v_delta), .chk_piece_type(chk_piece_type),
        .chk_valid_input(chk_valid_input), .chk_done(chk_done), .chk_move_ok(chk_move_ok),
        .result_valid(result_valid), .result_legal(result_legal), .result_code(result_code)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic load_board();
        for (int y = 0; y < 8; y++)
            for (int x = 0; x < 8; x++)
                board_in[(y*8+x)*4 +: 4] = brd[y][x];
    endtask

    task automatic start_board();
        int back [8] = '{3, 1, 2, 4, 5, 2, 1, 3};
        for (int y = 0; y < 8; y++)
            for (int x = 0; x < 8; x++)
                brd[y][x] = 4'd15;
        for (int x = 0; x < 8; x++) begin
            brd[0][x] = 4'(8 + back[x]);
            brd[1][x] = 4'd8;
            brd[6][x] = 4'd0;
            brd[7][x] = 4'(back[x]);
        end
    endtask

    // Rule-level verdict of the pre-checks; -1 means a checker must decide
    function automatic int precheck_code(int ox, int oy, int nx, int ny, logic sd);
        logic [3:0] s, d;
        s = brd[oy][ox];
        d = brd[ny][nx];
        if (ox == nx && oy == ny) return 5;
        if (s == 4'd15) return 2;
        if (int'(s[2:0]) >= NC) return 7;
        if (s[3] != sd) return 3;
        if (d != 4'd15 && d[3] == sd) return 4;
        return -1;
    endfunction

    function automatic int iabs(int v);
        return (v < 0) ? -v : v;
    endfunction

    // d = WAIT cycle (0-based) at which the selected checker raises done; -1 never
    task automatic run_move(input int ox, input int oy, input int nx, input int ny,
                            input logic sd, input int d, input logic ok, input string tag);
        int code, kind, lat, rv_first, rv_cnt, vi_cnt, vi_cyc;
        logic [NC-1:0] vi_val, nz, okv;
        logic leg;
        logic [2:0] cd;
        logic [3:0] src;
        bit issued;
        src  = brd[oy][ox];
        kind = int'(src[2:0]);
        code = precheck_code(ox, oy, nx, ny, sd);
        issued = (code < 0);
        if (issued) begin
            if (d >= 0 && d < TO) begin
                code = ok ? 0 : 1;
                lat  = 4 + d;
            end else begin
                code = 6;
                lat  = 3 + TO;
            end
        end else begin
            lat = 2;
        end
        rv_first = -1; rv_cnt = 0; vi_cnt = 0; vi_cyc = -1; vi_val = '0;
        leg = 1'bx; cd = 3'bx;

        load_board();
        @(negedge clk);
        old_x = 3'(ox); old_y = 3'(oy); new_x = 3'(nx); new_y = 3'(ny);
        side = sd; req_valid = 1'b1;
        #1 check({tag, ".req_ready"}, 32'(req_ready), 32'd1);
        @(posedge clk);
        #1 req_valid = 1'b0;
        old_x = 3'($urandom); old_y = 3'($urandom);
        new_x = 3'($urandom); new_y = 3'($urandom); side = 1'($urandom);

        for (int cyc = 1; cyc <= RUN_CYC; cyc++) begin
            nz  = NC'($urandom);
            okv = NC'($urandom);
            if (kind < NC) begin
                nz[kind]  = (d >= 0) && (cyc >= 3 + d);
                okv[kind] = ok;
            end
            chk_done = nz;
            chk_move_ok = okv;
            @(negedge clk);
            if (cyc == 1) begin
                check({tag, ".old_x"}, 32'(chk_old_x), 32'(ox));
                check({tag, ".new_y"}, 32'(chk_new_y), 32'(ny));
                check({tag, ".h_delta"}, 32'(chk_h_delta), 32'(iabs(nx - ox)));
                check({tag, ".v_delta"}, 32'(chk_v_delta), 32'(iabs(ny - oy)));
                check({tag, ".piece"}, 32'(chk_piece_type), 32'(src));
            end
            if (result_valid) begin
                rv_cnt++;
                if (rv_first < 0) begin
                    rv_first = cyc;
                    leg = result_legal;
                    cd = result_code;
                end
            end
            if (chk_valid_input != '0) begin
                vi_cnt++;
                vi_cyc = cyc;
                vi_val = chk_valid_input;
            end
            @(posedge clk);
            #1;
        end
        chk_done = '0;
        chk_move_ok = '0;

        check({tag, ".latency"}, 32'(rv_first), 32'(lat));
        check({tag, ".pulses"}, 32'(rv_cnt), 32'd1);
        check({tag, ".legal"}, 32'(leg), 32'(code == 0));
        check({tag, ".code"}, 32'(cd), 32'(code));
        check({tag, ".code_hold"}, 32'(result_code), 32'(code));
        check({tag, ".issue_cnt"}, 32'(vi_cnt), issued ? 32'd1 : 32'd0);
        if (issued) begin
            check({tag, ".issue_cyc"}, 32'(vi_cyc), 32'd2);
            check({tag, ".issue_vec"}, 32'(vi_val), 32'(1 << kind));
        end
    endtask

    initial begin
        int ox, oy, nx, ny, d;
        logic sd;
        start_board();
        load_board();
        repeat (3) @(posedge clk);
        #1;
        check("rst.req_ready", 32'(req_ready), 32'd1);
        check("rst.valid_input", 32'(chk_valid_input), 32'd0);
        check("rst.result_valid", 32'(result_valid), 32'd0);
        check("rst.result_legal", 32'(result_legal), 32'd0);
        check("rst.result_code", 32'(result_code), 32'd0);
        check("rst.h_delta", 32'(chk_h_delta), 32'd0);
        check("rst.piece", 32'(chk_piece_type), 32'd0);
        @(negedge clk);
        reset_n = 1'b1;

        // Directed scenarios
        run_move(0, 6, 0, 4, 1'b0, 0, 1'b1, "pawn_ok");
        run_move(3, 3, 3, 5, 1'b0, 0, 1'b1, "empty_src");
        brd[5][2] = 4'd3;
        run_move(1, 7, 2, 5, 1'b0, 0, 1'b1, "own_dest");
        start_board();
        run_move(0, 6, 0, 5, 1'b1, 0, 1'b1, "wrong_side");
        run_move(4, 6, 4, 6, 1'b0, 0, 1'b1, "null_move");
        run_move(0, 7, 0, 5, 1'b0, 70, 1'b1, "rook_timeout");
        run_move(2, 7, 4, 5, 1'b0, 5, 1'b0, "bishop_illegal");
        brd[4][4] = 4'd6;
        run_move(4, 4, 4, 3, 1'b0, 0, 1'b1, "bad_piece");
        start_board();

        // Reset in the middle of WAIT
        load_board();
        @(negedge clk);
        old_x = 3'd0; old_y = 3'd7; new_x = 3'd0; new_y = 3'd5; side = 1'b0;
        req_valid = 1'b1;
        @(posedge clk);
        #1 req_valid = 1'b0;
        repeat (10) @(posedge clk);
        #1 reset_n = 1'b0;
        #1;
        check("midrst.req_ready", 32'(req_ready), 32'd1);
        check("midrst.valid_input", 32'(chk_valid_input), 32'd0);
        check("midrst.result_valid", 32'(result_valid), 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        run_move(6, 7, 5, 5, 1'b0, 2, 1'b1, "after_rst");

        // Randomized moves on random boards
        for (int t = 0; t < 30; t++) begin
            for (int y = 0; y < 8; y++)
                for (int x = 0; x < 8; x++)
                    brd[y][x] = ($urandom_range(0, 2) == 0) ? 4'd15 : 4'($urandom_range(0, 15));
            ox = $urandom_range(0, 7); oy = $urandom_range(0, 7);
            if ($urandom_range(0, 5) == 0) begin
                nx = ox; ny = oy;
            end else begin
                nx = $urandom_range(0, 7); ny = $urandom_range(0, 7);
            end
            sd = ($urandom_range(0, 3) != 0) ? brd[oy][ox][3] : 1'($urandom);
            d = ($urandom_range(0, 7) == 0) ? 70 : $urandom_range(0, 12);
            run_move(ox, oy, nx, ny, sd, d, 1'($urandom), $sformatf("rnd%0d", t));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
